// File: rtl/status_tx.sv
`default_nettype none
// ============================================================================
// Module   : status_tx
// Brief    : Snapshots scanner status and writes a framed 10-byte packet into
//            the USB TX FIFO, only when the whole packet fits.
// Revision : 1.0 - initial release
// ============================================================================
module status_tx #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         PERIOD_CYC = 0,
    parameter int         PKT_LEN    = 10
) (
    input  logic        clk_100M,
    input  logic        nrst,
    input  logic        tx_req,
    input  logic        cont_en,
    input  logic [15:0] cont_gain,
    input  logic [15:0] cont_off,
    input  logic [15:0] scan_line,
    input  logic        scan_err,
    output logic        tx_busy,
    output logic        usb_wr_clk,
    output logic        usb_wr_valid,
    output logic [7:0]  usb_writedata,
    input  logic [7:0]  usb_txspace
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [7:0] c_LEN8     = 8'(PKT_LEN);
    localparam logic [3:0] c_IDX_END  = 4'(PKT_LEN);
    localparam logic [3:0] c_IDX_CSUM = 4'(PKT_LEN - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_pending;
    logic        r_busy;
    logic        r_valid;
    logic [7:0]  r_data;
    logic [3:0]  r_idx;
    logic [7:0]  r_csum;
    logic [7:0]  r_seq;
    logic        r_en;
    logic        r_err;
    logic [15:0] r_gain;
    logic [15:0] r_off;
    logic [15:0] r_line;
    logic        w_tick;
    logic        w_go;
    logic [7:0]  w_byte;

    assign usb_wr_clk    = clk_100M;
    assign usb_wr_valid  = r_valid;
    assign usb_writedata = r_data;
    assign tx_busy       = r_busy;

    generate
        if (PERIOD_CYC > 0) begin : g_period
            localparam int c_PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
            logic [c_PW-1:0] r_cnt;

            assign w_tick = (r_cnt == c_PW'(PERIOD_CYC - 1));

            always_ff @(posedge clk_100M or negedge nrst) begin
                if (!nrst) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end else begin : g_no_period
            assign w_tick = 1'b0;
        end
    endgenerate

    // A request in the current cycle counts immediately so SNAP follows it directly.
    assign w_go = (r_pending || tx_req || w_tick) && (usb_txspace >= c_LEN8);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_go) w_state_nxt = ST_SNAP;
            ST_SNAP: w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (r_idx == c_IDX_END) begin
                    w_state_nxt = w_go ? ST_SNAP : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd1:    w_byte = r_seq;
            4'd2:    w_byte = {6'b0, r_err, r_en};
            4'd3:    w_byte = r_gain[15:8];
            4'd4:    w_byte = r_gain[7:0];
            4'd5:    w_byte = r_off[15:8];
            4'd6:    w_byte = r_off[7:0];
            4'd7:    w_byte = r_line[15:8];
            4'd8:    w_byte = r_line[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (tx_req || w_tick) begin
                r_pending <= 1'b1;
            end else if (r_state == ST_SNAP) begin
                r_pending <= 1'b0;
            end
        end
    end

    // r_idx names the byte loaded at the next edge; the output register shows r_idx-1.
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_idx   <= 4'd0;
            r_csum  <= 8'h00;
            r_seq   <= 8'h00;
            r_en    <= 1'b0;
            r_err   <= 1'b0;
            r_gain  <= 16'h0000;
            r_off   <= 16'h0000;
            r_line  <= 16'h0000;
        end else begin
            case (r_state)
                ST_SNAP: begin
                    r_en    <= cont_en;
                    r_err   <= scan_err;
                    r_gain  <= cont_gain;
                    r_off   <= cont_off;
                    r_line  <= scan_line;
                    r_valid <= 1'b1;
                    r_data  <= SYNC_BYTE;
                    r_csum  <= SYNC_BYTE;
                    r_idx   <= 4'd1;
                end
                ST_SEND: begin
                    if (r_idx == c_IDX_END) begin
                        r_valid <= 1'b0;
                        r_data  <= 8'h00;
                        r_idx   <= 4'd0;
                        r_seq   <= r_seq + 8'd1;
                    end else if (r_idx == c_IDX_CSUM) begin
                        r_data <= r_csum;
                        r_idx  <= r_idx + 4'd1;
                    end else begin
                        r_data <= w_byte;
                        r_csum <= r_csum + w_byte;
                        r_idx  <= r_idx + 4'd1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_tx
// Brief    : Directed self-checking bench for status_tx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_tx;

    logic        clk_100M = 1'b0;
    logic        nrst     = 1'b0;
    logic        nrst_p   = 1'b0;
    logic        tx_req   = 1'b0;
    logic        cont_en  = 1'b0;
    logic [15:0] cont_gain = 16'h0;
    logic [15:0] cont_off  = 16'h0;
    logic [15:0] scan_line = 16'h0;
    logic        scan_err = 1'b0;
    logic [7:0]  usb_txspace   = 8'd32;
    logic [7:0]  usb_txspace_p = 8'd32;

    logic        tx_busy, usb_wr_clk, usb_wr_valid;
    logic [7:0]  usb_writedata;
    logic        p_busy, p_wr_clk, p_wr_valid;
    logic [7:0]  p_writedata;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [7:0] bytes[$];
    int         bcyc[$];
    logic [7:0] pbytes[$];
    int         pcyc[$];

    status_tx #(.SYNC_BYTE(8'hA5), .PERIOD_CYC(0), .PKT_LEN(10)) u_dut (
        .clk_100M(clk_100M), .nrst(nrst), .tx_req(tx_req),
        .cont_en(cont_en), .cont_gain(cont_gain), .cont_off(cont_off),
        .scan_line(scan_line), .scan_err(scan_err), .tx_busy(tx_busy),
        .usb_wr_clk(usb_wr_clk), .usb_wr_valid(usb_wr_valid),
        .usb_writedata(usb_writedata), .usb_txspace(usb_txspace)
    );

    status_tx #(.SYNC_BYTE(8'hA5), .PERIOD_CYC(100), .PKT_LEN(10)) u_per (
        .clk_100M(clk_100M), .nrst(nrst_p), .tx_req(1'b0),
        .cont_en(cont_en), .cont_gain(cont_gain), .cont_off(cont_off),
        .scan_line(scan_line), .scan_err(scan_err), .tx_busy(p_busy),
        .usb_wr_clk(p_wr_clk), .usb_wr_valid(p_wr_valid),
        .usb_writedata(p_writedata), .usb_txspace(usb_txspace_p)
    );

    always #5 clk_100M = ~clk_100M;

    always @(posedge clk_100M) cyc <= cyc + 1;

    always @(negedge clk_100M) begin
        if (usb_wr_valid) begin
            bytes.push_back(usb_writedata);
            bcyc.push_back(cyc);
        end
        if (p_wr_valid) begin
            pbytes.push_back(p_writedata);
            pcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_cap();
        bytes.delete();
        bcyc.delete();
    endtask

    task automatic set_fields(input logic en, input logic err, input logic [15:0] g,
                              input logic [15:0] o, input logic [15:0] l);
        cont_en = en; scan_err = err; cont_gain = g; cont_off = o; scan_line = l;
    endtask

    // Pulses tx_req for one cycle; returns the cycle number it was driven in.
    task automatic drive_req(output int c);
        @(negedge clk_100M);
        tx_req = 1'b1;
        c = cyc;
        @(negedge clk_100M);
        tx_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_100M);
        nrst = 1'b0;
        repeat (2) @(negedge clk_100M);
        nrst = 1'b1;
    endtask

    task automatic check_pkt(input string tag, input int base, input logic [7:0] sq,
                             input logic en, input logic err, input logic [15:0] g,
                             input logic [15:0] o, input logic [15:0] l);
        logic [7:0] e [10];
        logic [7:0] sum;
        e[0] = 8'hA5; e[1] = sq; e[2] = {6'b0, err, en};
        e[3] = g[15:8]; e[4] = g[7:0]; e[5] = o[15:8]; e[6] = o[7:0];
        e[7] = l[15:8]; e[8] = l[7:0];
        sum = 8'h00;
        for (int i = 0; i < 9; i++) sum = sum + e[i];
        e[9] = sum;
        if (bytes.size() < base + 10) begin
            check($sformatf("%s_len", tag), bytes.size(), base + 10);
        end else begin
            for (int i = 0; i < 10; i++)
                check($sformatf("%s_b%0d", tag, i), bytes[base+i], e[i]);
        end
    endtask

    logic [7:0] exp1 [10];
    logic [15:0] wg [257];
    logic [15:0] wo [257];
    logic [15:0] wl [257];
    logic        wen [257];
    logic        werr [257];

    initial begin
        int c0;
        int c1;
        int cp0;
        exp1 = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00, 8'h56, 8'h01, 8'h02, 8'h45};

        // Reset state
        repeat (3) @(negedge clk_100M);
        check("rst_valid", usb_wr_valid, 1'b0);
        check("rst_data", usb_writedata, 8'h00);
        check("rst_busy", tx_busy, 1'b0);
        nrst = 1'b1;
        repeat (2) @(negedge clk_100M);
        check("idle_valid", usb_wr_valid, 1'b0);

        // Single packet, hand-computed bytes
        set_fields(1'b1, 1'b0, 16'h1234, 16'h0056, 16'h0102);
        usb_txspace = 8'd32;
        clear_cap();
        drive_req(c0);
        check("single_busy_snap", tx_busy, 1'b1);
        repeat (20) @(negedge clk_100M);
        check("single_len", bytes.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < bytes.size()) check($sformatf("single_b%0d", i), bytes[i], exp1[i]);
        if (bytes.size() == 10) begin
            check("single_lat", bcyc[0] - c0, 2);
            check("single_contig", bcyc[9] - bcyc[0], 9);
        end
        check("single_busy_end", tx_busy, 1'b0);

        // Space gating
        clear_cap();
        usb_txspace = 8'd9;
        drive_req(c0);
        repeat (50) @(negedge clk_100M);
        check("gate_novalid", bytes.size(), 0);
        check("gate_busy", tx_busy, 1'b0);
        usb_txspace = 8'd10;
        c1 = cyc;
        repeat (15) @(negedge clk_100M);
        usb_txspace = 8'd32;
        check_pkt("gate", 0, 8'h01, 1'b1, 1'b0, 16'h1234, 16'h0056, 16'h0102);
        check("gate_len", bytes.size(), 10);
        if (bytes.size() > 0) check("gate_lat", bcyc[0] - c1, 2);

        // Coalescing: three requests during packet seq=0
        do_reset();
        clear_cap();
        set_fields(1'b0, 1'b1, 16'hBEEF, 16'h0A0B, 16'hFF00);
        drive_req(c0);
        repeat (2) @(negedge clk_100M);
        for (int k = 0; k < 3; k++) begin
            tx_req = 1'b1;
            @(negedge clk_100M);
            tx_req = 1'b0;
            @(negedge clk_100M);
        end
        repeat (40) @(negedge clk_100M);
        check("coal_len", bytes.size(), 20);
        check_pkt("coal0", 0, 8'h00, 1'b0, 1'b1, 16'hBEEF, 16'h0A0B, 16'hFF00);
        check_pkt("coal1", 10, 8'h01, 1'b0, 1'b1, 16'hBEEF, 16'h0A0B, 16'hFF00);
        if (bytes.size() >= 20) check("coal_gap", bcyc[10] - bcyc[9], 2);

        // Reset mid-packet during byte 4
        clear_cap();
        set_fields(1'b1, 1'b0, 16'h1234, 16'h0056, 16'h0102);
        drive_req(c0);
        repeat (5) @(negedge clk_100M);
        check("mid_valid_b4", usb_wr_valid, 1'b1);
        check("mid_data_b4", usb_writedata, 8'h34);
        #2 nrst = 1'b0;
        #1;
        check("mid_async_valid", usb_wr_valid, 1'b0);
        check("mid_async_busy", tx_busy, 1'b0);
        repeat (2) @(negedge clk_100M);
        nrst = 1'b1;
        clear_cap();
        drive_req(c0);
        repeat (15) @(negedge clk_100M);
        check("mid_after_len", bytes.size(), 10);
        check_pkt("mid_after", 0, 8'h00, 1'b1, 1'b0, 16'h1234, 16'h0056, 16'h0102);

        // Sequence wrap over 257 packets; inputs scrambled after each snapshot
        do_reset();
        clear_cap();
        for (int p = 0; p < 257; p++) begin
            logic [7:0] pb;
            pb = 8'(p);
            wg[p] = {pb, ~pb}; wo[p] = 16'(p * 3); wl[p] = 16'hFFFF - 16'(p);
            wen[p] = pb[0]; werr[p] = pb[1];
            set_fields(wen[p], werr[p], wg[p], wo[p], wl[p]);
            drive_req(c0);
            @(negedge clk_100M);
            set_fields(~wen[p], ~werr[p], ~wg[p], ~wo[p], ~wl[p]);
            repeat (11) @(negedge clk_100M);
        end
        check("wrap_len", bytes.size(), 2570);
        for (int p = 0; p < 257; p++)
            check_pkt($sformatf("wrap%0d", p), p * 10, 8'(p), wen[p], werr[p], wg[p], wo[p], wl[p]);

        // Periodic instance, PERIOD_CYC=100
        set_fields(1'b1, 1'b0, 16'h1234, 16'h0056, 16'h0102);
        @(negedge clk_100M);
        nrst_p = 1'b1;
        cp0 = cyc;
        repeat (1100) @(negedge clk_100M);
        check("per_enough", 32'(pbytes.size() >= 100), 1);
        if (pbytes.size() >= 100) begin
            check("per_first", pcyc[0] - cp0, 101);
            for (int k = 0; k < 10; k++) begin
                check($sformatf("per_sync%0d", k), pbytes[k*10], 8'hA5);
                check($sformatf("per_seq%0d", k), pbytes[k*10+1], 8'(k));
                check($sformatf("per_csum%0d", k), pbytes[k*10+9], 8'(8'h45 + 8'(k)));
                if (k > 0)
                    check($sformatf("per_space%0d", k), pcyc[k*10] - pcyc[(k-1)*10], 100);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
